// File: rtl/instr_sequencer.sv
// Control unit that issues a loadable {opcode, operand1, operand2} program to
// the processor, one instruction every three cycles, and reports each result.
module instr_sequencer #(
    parameter int         ADDR_W  = 4,
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [23:0]       prog_data,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    output logic [7:0]        opcode,
    output logic [7:0]        operand1,
    output logic [7:0]        operand2,
    input  logic [7:0]        result,
    input  logic [7:0]        flags,
    output logic              busy,
    output logic              done,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [15:0]       res_data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_HOLD    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // A halt word is never presented to the processor; its slot issues zeros.
    function automatic logic [23:0] issue_word(input logic [23:0] w);
        if (w[23:16] == HALT_OP) begin
            return 24'h000000;
        end else begin
            return w;
        end
    endfunction

    logic [23:0]       mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        flags_cap_q, flags_cap_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              res_we_q, res_we_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic [15:0]       res_data_q, res_data_d;

    logic              mem_we_s;
    logic [ADDR_W-1:0] fetch_addr_s;
    logic [23:0]       fetch_word_s;
    logic              halt_s;
    logic              last_s;

    assign mem_we_s     = prog_we & ~busy_q;
    assign fetch_addr_s = (state_q == S_IDLE) ? {ADDR_W{1'b0}} : (pc_q + ADDR_W'(1));
    // Forward a same-cycle write so a start alongside prog_we sees the new word.
    assign fetch_word_s = (mem_we_s && (prog_addr == fetch_addr_s)) ? prog_data
                                                                     : mem_q[fetch_addr_s];
    assign halt_s       = (mem_q[pc_q][23:16] == HALT_OP);
    assign last_s       = (({1'b0, pc_q} + (ADDR_W+1)'(1)) == len_q) ||
                          (pc_q == {ADDR_W{1'b1}});

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // Next-state and output-register computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        word_d      = word_q;
        flags_cap_d = flags_cap_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_we_d    = 1'b0;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = prog_len;
                    pc_d  = {ADDR_W{1'b0}};
                    if (prog_len == {(ADDR_W+1){1'b0}}) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                        busy_d  = 1'b1;
                        word_d  = issue_word(fetch_word_s);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (halt_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    word_d  = 24'h000000;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                flags_cap_d = flags;
                state_d     = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_data_d = {flags_cap_q, result};
                res_addr_d = pc_q;
                res_we_d   = 1'b1;
                if (last_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    word_d  = 24'h000000;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                    word_d  = issue_word(fetch_word_s);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                word_d  = 24'h000000;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                word_d  = 24'h000000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= {ADDR_W{1'b0}};
            len_q       <= {(ADDR_W+1){1'b0}};
            word_q      <= 24'h000000;
            flags_cap_q <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_we_q    <= 1'b0;
            res_addr_q  <= {ADDR_W{1'b0}};
            res_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            word_q      <= word_d;
            flags_cap_q <= flags_cap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_we_q    <= res_we_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
        end
    end

    assign opcode   = word_q[23:16];
    assign operand1 = word_q[15:8];
    assign operand2 = word_q[7:0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign res_we   = res_we_q;
    assign res_addr = res_addr_q;
    assign res_data = res_data_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer driving a registered adder processor model.
module tb_instr_sequencer;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [23:0]       prog_data = '0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   prog_len = '0;
    logic [7:0]        opcode, operand1, operand2, result, flags;
    logic              busy, done, res_we;
    logic [ADDR_W-1:0] res_addr;
    logic [15:0]       res_data;

    instr_sequencer #(.ADDR_W(ADDR_W), .HALT_OP(8'hFF)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .prog_len(prog_len),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .result(result), .flags(flags), .busy(busy), .done(done),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // Processor model: operands latched, flags combinational, result one cycle later.
    logic [7:0] op1_r, op2_r, res_r;
    always_ff @(posedge clk) begin
        op1_r <= operand1;
        op2_r <= operand2;
        res_r <= op1_r + op2_r;
    end
    assign result = res_r;
    assign flags  = {7'b0000000, ((op1_r + op2_r) == 8'h00)};

    int n_checks = 0;
    int n_fail   = 0;
    logic [19:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    int cyc = 0, n_we = 0, n_done = 0, n_busy = 0, n_ff = 0, n_hold = 0;
    int we_cyc = 0, done_cyc = 0, start_cyc = 0;

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (start) start_cyc <= cyc;
        if (busy) n_busy <= n_busy + 1;
        if (opcode == 8'hFF) n_ff <= n_ff + 1;
        if ({opcode, operand1, operand2} == 24'h010503) n_hold <= n_hold + 1;
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (res_we) begin
            n_we   <= n_we + 1;
            we_cyc <= cyc;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_res_we", {12'h000, res_addr, res_data}, 32'h0);
            end else begin
                check_eq("res", {12'h000, res_addr, res_data}, {12'h000, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [23:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic expect_res(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Start a program and wait (bounded) for done; poke drives write+start while busy.
    task automatic run_prog(input logic [ADDR_W:0] len, input bit poke);
        int d0;
        d0 = n_done;
        prog_len = len; start = 1'b1;
        step();
        start = 1'b0;
        if (poke) begin
            step();
            prog_we = 1'b1; prog_addr = '0; prog_data = 24'h027777;
            start = 1'b1; prog_len = 5'd1;
            step();
            prog_we = 1'b0; start = 1'b0;
        end
        for (int i = 0; i < 200 && n_done == d0; i++) step();
        check_eq("done_seen", {31'd0, n_done != d0}, 32'd1);
        step(); step();
        check_eq("sb_empty", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    int w0, d0, b0, f0, h0;

    initial begin
        repeat (3) step();
        check_eq("reset_outs", {5'd0, busy, done, res_we, opcode, operand1, operand2}, 32'd0);
        check_eq("reset_res", {12'h000, res_addr, res_data}, 32'd0);
        reset = 1'b0;
        step();

        // Single instruction 05+03.
        write_mem(4'd0, 24'h010503);
        expect_res(4'd0, 16'h0008);
        w0 = n_we; d0 = n_done; h0 = n_hold;
        run_prog(5'd1, 1'b0);
        check_eq("t1_we", n_we - w0, 32'd1);
        check_eq("t1_done", n_done - d0, 32'd1);
        check_eq("t1_hold3", n_hold - h0, 32'd3);
        check_eq("t1_done_with_we", done_cyc, we_cyc);
        check_eq("t1_busy_low", {31'd0, busy}, 32'd0);

        // Write and start in the same cycle: new word must be used.
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 24'h010101;
        expect_res(4'd0, 16'h0002);
        run_prog(5'd1, 1'b0);
        prog_we = 1'b0;

        // Three-instruction program.
        write_mem(4'd0, 24'h021020);
        write_mem(4'd1, 24'h02FF01);
        write_mem(4'd2, 24'h020000);
        expect_res(4'd0, 16'h0030);
        expect_res(4'd1, 16'h0100);
        expect_res(4'd2, 16'h0100);
        w0 = n_we; b0 = n_busy;
        run_prog(5'd3, 1'b0);
        check_eq("t2_we", n_we - w0, 32'd3);
        check_eq("t2_busy9", n_busy - b0, 32'd9);

        // Halt opcode at address 1.
        write_mem(4'd1, 24'hFF1111);
        expect_res(4'd0, 16'h0030);
        w0 = n_we; f0 = n_ff;
        run_prog(5'd4, 1'b0);
        check_eq("halt_we", n_we - w0, 32'd1);
        check_eq("halt_done_gap", done_cyc - we_cyc, 32'd1);
        check_eq("halt_no_ff", n_ff - f0, 32'd0);
        write_mem(4'd1, 24'h02FF01);

        // Zero-length program.
        w0 = n_we;
        run_prog(5'd0, 1'b0);
        check_eq("len0_we", n_we - w0, 32'd0);
        check_eq("len0_done_next", done_cyc - start_cyc, 32'd1);

        // Reset during HOLD of instruction 1.
        expect_res(4'd0, 16'h0030);
        w0 = n_we; d0 = n_done;
        prog_len = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check_eq("mid_in_instr1", {8'h00, opcode, operand1, operand2}, 32'h0002FF01);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_reset_outs", {5'd0, busy, done, res_we, opcode, operand1, operand2}, 32'd0);
        repeat (10) step();
        check_eq("mid_we", n_we - w0, 32'd1);
        check_eq("mid_no_done", n_done - d0, 32'd0);
        check_eq("mid_sb_empty", exp_q.size(), 32'd0);
        exp_q.delete();
        expect_res(4'd0, 16'h0030);
        expect_res(4'd1, 16'h0100);
        expect_res(4'd2, 16'h0100);
        run_prog(5'd3, 1'b0);

        // Write and start while busy are ignored.
        expect_res(4'd0, 16'h0030);
        expect_res(4'd1, 16'h0100);
        expect_res(4'd2, 16'h0100);
        w0 = n_we; d0 = n_done;
        run_prog(5'd3, 1'b1);
        check_eq("busy_ign_we", n_we - w0, 32'd3);
        check_eq("busy_ign_done", n_done - d0, 32'd1);
        expect_res(4'd0, 16'h0030);
        run_prog(5'd1, 1'b0);

        // Over-length program runs every address once and stops.
        for (int i = 0; i < 16; i++) begin
            write_mem(4'(i), {8'h02, 8'(i), 8'h01});
            expect_res(4'(i), {8'h00, 8'(i + 1)});
        end
        w0 = n_we; d0 = n_done;
        run_prog(5'd17, 1'b0);
        check_eq("full_we", n_we - w0, 32'd16);
        check_eq("full_done", n_done - d0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
